ccu_coinc_bank: RTL and testbench
=================================

# ccu_coinc_bank

Parametrised next-generation coincidence counting bank for the coincidence counting unit. It accepts N_CH single-cycle detector pulses and counts singles per channel plus N_COINC configurable coincidence masks over a fixed batch period. At each batch end it snapshots all counts into a shadow bank and streams them out word by word over a valid/ready handshake to the serial transmitter. It replaces the fixed 4-channel, 9-counter, 8-bit counting stage and its batch monitor.

## Interface
- N_CH, 4: number of input channels. Bit 0=A, 1=B, 2=BP, 3=AP.
- N_COINC, 5: number of coincidence counters.
- CNT_W, 16: width of every counter and of out_data.
- BATCH_CYC, 100_000_000: batch length in clk cycles, ≥ N_WORDS+2.
- COINC_MASKS, 20'h7CA53: N_COINC×N_CH packed masks, mask k at bits [k*N_CH +: N_CH]. Default is AB, ABP, APB, APBP, ABBP.
- clk input 1: system clock.
- rst input 1: asynchronous, active-high reset.
- pulse_i input N_CH: single-cycle, clk-synchronous detector pulses.
- out_valid output 1: stream word valid.
- out_ready input 1: downstream accepts word.
- out_data output CNT_W: count word.
- out_idx output $clog2(N_WORDS): word index.
- out_last output 1: final word of frame.
- batch_done_o output 1: one-cycle pulse per batch end.
- overrun_o output 1: one-cycle pulse when a snapshot is dropped.

## Operation
- N_WORDS = N_CH + N_COINC. Frame order: singles 0..N_CH-1, then coincidences 0..N_COINC-1.
- Single counter c increments in any cycle where pulse_i[c]=1.
- Coincidence counter k increments in any cycle where (pulse_i & mask_k) == mask_k, with mask_k nonzero. An all-zero mask never counts.
- One cycle increments each counter by at most 1.
- Batch timer runs free from 0 to BATCH_CYC-1, then wraps to 0. The cycle with timer = BATCH_CYC-1 is the terminal cycle (T).
- At T:
  - The live value, including T's increment, is captured.
  - All live counters restart at 0 in T+1.
- FSM states: IDLE and SEND.
  - IDLE, at T: shadow ← captured values, state → SEND, idx=0.
  - SEND: a transfer occurs when out_valid && out_ready. idx increments on each transfer. A transfer with idx=N_WORDS-1 (out_last=1) returns the FSM to IDLE.
  - SEND, at T: the snapshot is dropped, the shadow is untouched, and overrun_o pulses. Live counters still clear, so that batch is lost.
- out_data=shadow[idx] and out_last=(idx==N_WORDS-1) whenever out_valid=1. Both are held stable while out_valid && !out_ready.
- Reset (asynchronous, any time including mid-stream):
  - Counters, shadow and timer go to 0; FSM goes to IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, batch_done_o=0, overrun_o=0.
  - Any frame in progress is aborted and not resumed.

## Timing
- out_valid rises in cycle T+1 (registered). batch_done_o pulses in T+1. overrun_o pulses in T+1.
- With out_ready held high, one word transfers per cycle. The frame occupies cycles T+1..T+N_WORDS, and the FSM is back in IDLE at T+N_WORDS+1.
- A pulse in T is in batch n. A pulse in T+1 is in batch n+1.
- The first batch after reset ends BATCH_CYC cycles after rst deasserts.
- No combinational path from out_ready to out_valid or out_data.

## Configuration
- CCU_SATURATE_EN:
  - Defined: live counters stop at 2^CNT_W-1 and ignore further increments until the batch clears them.
  - Undefined: counters wrap modulo 2^CNT_W.
- Behaviour is identical for singles and coincidence counters.

## Structure
- Package ccu_pkg holds:
  - the default mask constants (MASK_AB, MASK_ABP, MASK_APB, MASK_APBP, MASK_ABBP);
  - the channel-index constants (CH_A, CH_B, CH_BP, CH_AP);
  - the FSM state enum.
- Sub-module ccu_counter: one live counter with increment, clear-on-T and CCU_SATURATE_EN logic. It is instantiated N_WORDS times via generate.
- The batch timer, shadow bank and stream FSM live in the top.

## Test plan
Bench settings: N_CH=4, default masks, CNT_W=8, BATCH_CYC=100.
- **Singles and AB counts:** 10 pulses on A, with 3 of them also on B, within one batch → frame 10,3,0,0,3,0,0,0,0. out_last=1 only on idx 8.
- **All channels at once:** all four channels pulse in the same cycle, once → frame 1,1,1,1,1,1,1,1,1.
- **Saturation:** A pulses on 300 cycles across a BATCH_CYC=400 run → word 0 = 255 with CCU_SATURATE_EN, 44 without.
- **Batch boundary:** pulse on A in T and again in T+1 → batch n word 0 = 1, batch n+1 word 0 = 1. batch_done_o pulses once per batch.
- **Backpressure overrun:** out_ready low for 150 cycles from T+1 → overrun_o pulses at the next T+1. The held frame is unchanged, and after out_ready rises all 9 original words stream in order.
- **Reset mid-stream:** rst asserted at idx 4 → out_valid=0 immediately. After release, no frame until the first full batch, and that frame starts at idx 0.

Source files
------------

// File: rtl/ccu_pkg.sv
// ccu_pkg: channel indices, default coincidence masks and stream FSM states for ccu_coinc_bank
package ccu_pkg;
    localparam int CH_A  = 0;
    localparam int CH_B  = 1;
    localparam int CH_BP = 2;
    localparam int CH_AP = 3;
    localparam logic [3:0] MASK_AB   = 4'b0011;
    localparam logic [3:0] MASK_ABP  = 4'b0101;
    localparam logic [3:0] MASK_APB  = 4'b1010;
    localparam logic [3:0] MASK_APBP = 4'b1100;
    localparam logic [3:0] MASK_ABBP = 4'b0111;
    typedef enum logic {ST_IDLE, ST_SEND} state_t;
endpackage

// File: rtl/ccu_counter.sv
// ccu_counter: one live counter cleared at batch end; CCU_SATURATE_EN holds it at full scale instead of wrapping
module ccu_counter #(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_next
);
    logic [CNT_W-1:0] r_cnt;
`ifdef CCU_SATURATE_EN
    assign o_next = (i_inc && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
`else
    assign o_next = i_inc ? r_cnt + 1'b1 : r_cnt;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else     r_cnt <= i_clr ? '0 : o_next;
endmodule

// File: rtl/ccu_coinc_bank.sv
// ccu_coinc_bank: singles/coincidence counting bank with batch snapshot and valid/ready word stream; CCU_SATURATE_EN selects saturating counters
module ccu_coinc_bank
    import ccu_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int N_COINC = 5,
    parameter int CNT_W = 16,
    parameter int BATCH_CYC = 100_000_000,
    parameter logic [N_COINC*N_CH-1:0] COINC_MASKS = {MASK_ABBP, MASK_APBP, MASK_APB, MASK_ABP, MASK_AB},
    localparam int N_WORDS = N_CH + N_COINC,
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  pulse_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             batch_done_o,
    output logic             overrun_o
);
    localparam int TMR_W = (BATCH_CYC > 1) ? $clog2(BATCH_CYC) : 1;
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(BATCH_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    logic [TMR_W-1:0]                r_timer;
    logic                            w_term;
    logic [N_WORDS-1:0]              w_inc;
    logic [N_WORDS-1:0][CNT_W-1:0]   w_cap;
    logic [N_WORDS-1:0][CNT_W-1:0]   r_shadow;
    state_t                          r_state, w_state_nxt;
    logic [IDX_W-1:0]                r_idx, w_idx_nxt;
    logic                            w_load, r_done, r_ovr;

    assign w_term = r_timer == T_LAST;

    genvar i;
    for (i = 0; i < N_WORDS; i++) begin : g_cnt
        if (i < N_CH) begin : g_single
            assign w_inc[i] = pulse_i[i];
        end else begin : g_coinc
            localparam logic [N_CH-1:0] M = COINC_MASKS[(i-N_CH)*N_CH +: N_CH];
            assign w_inc[i] = (|M) && ((pulse_i & M) == M);
        end
        ccu_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .i_inc  (w_inc[i]),
            .i_clr  (w_term),
            .o_next (w_cap[i])
        );
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_timer  <= '0;
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_timer <= w_term ? '0 : r_timer + 1'b1;
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) r_shadow <= w_cap;
            r_done  <= w_term;
            r_ovr   <= w_term && r_state == ST_SEND;
        end

    // a batch ending while a frame is still streaming is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_term) begin
                w_state_nxt = ST_SEND;
                w_idx_nxt   = '0;
                w_load      = 1'b1;
            end
        end else if (out_ready) begin
            w_state_nxt = (r_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
            w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign out_valid    = r_state == ST_SEND;
    assign out_data     = out_valid ? r_shadow[r_idx] : '0;
    assign out_idx      = r_idx;
    assign out_last     = out_valid && r_idx == LAST_IDX;
    assign batch_done_o = r_done;
    assign overrun_o    = r_ovr;
endmodule

// File: tb/tb_ccu_coinc_bank.sv
// tb_ccu_coinc_bank: random and directed stimulus against a per-batch counting model of ccu_coinc_bank
module tb_ccu_coinc_bank;
    localparam int NW = 9;
    localparam int BC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pulse = '0;
    logic       ready = 1'b1;
    logic       valid, last, done, ovr;
    logic [7:0] data;
    logic [3:0] idx;

    logic       rst2 = 1'b1;
    logic [3:0] pulse2 = '0;
    logic       valid2, last2, done2, ovr2;
    logic [7:0] data2;
    logic [3:0] idx2;

    int n_pass = 0;
    int n_chk = 0;
    int acc [NW];
    int frame [NW];
    int cyc = 0;
    int pos = 0;
    logic busy = 1'b0;
    logic [3:0] masks [5];

    always #5 clk = ~clk;

    ccu_coinc_bank #(.N_CH(4), .N_COINC(5), .CNT_W(8), .BATCH_CYC(BC)) dut (
        .clk(clk), .rst(rst), .pulse_i(pulse), .out_valid(valid), .out_ready(ready),
        .out_data(data), .out_idx(idx), .out_last(last), .batch_done_o(done), .overrun_o(ovr)
    );

    ccu_coinc_bank #(.N_CH(4), .N_COINC(5), .CNT_W(8), .BATCH_CYC(400)) dut_sat (
        .clk(clk), .rst(rst2), .pulse_i(pulse2), .out_valid(valid2), .out_ready(1'b1),
        .out_data(data2), .out_idx(idx2), .out_last(last2), .batch_done_o(done2), .overrun_o(ovr2)
    );

    function automatic int fold(input int v);
`ifdef CCU_SATURATE_EN
        return v > 255 ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        acc  = '{default: 0};
        cyc  = 0;
        pos  = 0;
        busy = 1'b0;
    endtask

    task automatic tick(input logic [3:0] p);
        logic was_busy, xfer, ended;
        pulse = p;
        for (int c = 0; c < 4; c++) acc[c] += int'(p[c]);
        for (int k = 0; k < 5; k++)
            if (masks[k] != 0 && (p & masks[k]) == masks[k]) acc[4+k]++;
        was_busy = busy;
        xfer = busy && ready;
        @(negedge clk);
        if (xfer) begin
            pos++;
            if (pos == NW) begin
                busy = 1'b0;
                pos  = 0;
            end
        end
        ended = cyc == BC - 1;
        if (ended) begin
            if (!was_busy) begin
                for (int w = 0; w < NW; w++) frame[w] = fold(acc[w]);
                busy = 1'b1;
                pos  = 0;
            end
            acc = '{default: 0};
            cyc = 0;
        end else cyc++;
        check("batch_done", done, ended);
        check("overrun", ovr, ended && was_busy);
        check("out_valid", valid, busy);
        if (busy) begin
            check("out_data", data, frame[pos]);
            check("out_idx", idx, pos);
            check("out_last", last, pos == NW - 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_idx"}, idx, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovr"}, ovr, 0);
    endtask

    initial begin
        masks[0] = 4'b0011;
        masks[1] = 4'b0101;
        masks[2] = 4'b1010;
        masks[3] = 4'b1100;
        masks[4] = 4'b0111;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < BC; i++) tick(i < 10 ? (i < 3 ? 4'b0011 : 4'b0001) : 4'b0000);
        for (int i = 0; i < BC; i++) tick(i == 50 ? 4'b1111 : 4'b0000);
        for (int i = 0; i < 2 * BC; i++) tick(4'($urandom()));
        while (cyc != BC - 1) tick(4'($urandom()));
        tick(4'b0001);
        tick(4'b0001);
        for (int i = 0; i < BC - 1; i++) tick(4'b0000);
        for (int i = 0; i < 12; i++) tick(4'($urandom()));
        while (cyc != BC - 1) tick(4'($urandom()));
        tick(4'($urandom()));
        ready = 1'b0;
        for (int i = 0; i < 150; i++) tick(4'($urandom()));
        ready = 1'b1;
        for (int i = 0; i < 120; i++) tick(4'($urandom()));
        for (int i = 0; i < 300 && !(busy && pos == 4); i++) tick(4'($urandom()));
        check("midstream_idx", idx, 4);
        rst   = 1'b1;
        pulse = '0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < BC + 12; i++) tick(4'($urandom()));
        rst2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            pulse2 = (i < 300) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        check("sat_valid", valid2, 1);
        check("sat_done", done2, 1);
        check("sat_idx", idx2, 0);
        check("sat_word0", data2, fold(300));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
